coeff_frame_ctrl: RTL and testbench

COEFF_FRAME_CTRL -- requirements
Module: coeff_frame_ctrl

---
 rtl/coeff_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_coeff_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_frame_ctrl.sv
// rtl/coeff_frame_ctrl.sv - CPU-programmable FIR coefficient bank with frame-synchronous commit
`timescale 1ns/1ps

module coeff_frame_ctrl #(
  parameter int          NUM_COEFF  = 9,
  parameter logic [15:0] CENTER_RST = 16'h0100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      axi_wr_strobe_i,
  input  logic                      axi_rd_strobe_i,
  output logic                      axi_wr_ack_o,
  output logic                      axi_rd_ack_o,
  input  logic [15:0]               fir_addr_from_axi,
  input  logic [15:0]               fir_coeff_from_axi,
  output logic [15:0]               hist_bin_to_axi,
  input  logic                      vs_i,
  output logic [7:0]                hist_rd_addr_o,
  input  logic [15:0]               hist_rd_data_i,
  output logic [16*NUM_COEFF-1:0]   coeff_o,
  output logic                      commit_pulse_o
);

  localparam int          IDX_W  = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam int          CENTER = NUM_COEFF / 2;
  localparam logic [15:0] NC16   = 16'(NUM_COEFF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_ACK
  } state_t;

  state_t                  r_state;
  logic                    r_wr_meta, r_wr_sync;
  logic                    r_rd_meta, r_rd_sync;
  logic                    r_is_wr;
  logic [15:0]             r_addr;
  logic [15:0]             r_data;
  logic [15:0]             r_shadow [NUM_COEFF];
  logic [16*NUM_COEFF-1:0] r_coeff;
  logic                    r_pending;
  logic                    r_vs_d;
  logic                    r_commit_pulse;
  logic                    r_wr_ack, r_rd_ack;
  logic [7:0]              r_hist_addr;
  logic [15:0]             r_rd_data;

  logic                    w_in_bank;
  logic                    w_in_hist;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_vs_rise;
  logic                    w_ack_strobe;
  logic [15:0]             w_rd_mux;

  assign w_in_bank    = (r_addr < NC16);
  assign w_in_hist    = (r_addr[15:8] == 8'h01);
  assign w_idx        = r_addr[IDX_W-1:0];
  assign w_vs_rise    = vs_i & ~r_vs_d;
  assign w_ack_strobe = r_is_wr ? r_wr_sync : r_rd_sync;

  // Histogram data is already valid in RD_WAIT, one cycle after the address went out.
  always_comb begin
    w_rd_mux = 16'h0000;
    if (w_in_bank)
      w_rd_mux = r_shadow[w_idx];
    else if (w_in_hist)
      w_rd_mux = hist_rd_data_i;
    else if (r_addr == 16'h0201)
      w_rd_mux = {15'b0, r_pending};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_wr_meta      <= 1'b0;
      r_wr_sync      <= 1'b0;
      r_rd_meta      <= 1'b0;
      r_rd_sync      <= 1'b0;
      r_is_wr        <= 1'b0;
      r_addr         <= 16'h0000;
      r_data         <= 16'h0000;
      r_pending      <= 1'b0;
      r_vs_d         <= 1'b0;
      r_commit_pulse <= 1'b0;
      r_wr_ack       <= 1'b0;
      r_rd_ack       <= 1'b0;
      r_hist_addr    <= 8'h00;
      r_rd_data      <= 16'h0000;
      for (int i = 0; i < NUM_COEFF; i++) begin
        r_shadow[i]         <= (i == CENTER) ? CENTER_RST : 16'h0000;
        r_coeff[i*16 +: 16] <= (i == CENTER) ? CENTER_RST : 16'h0000;
      end
    end else begin
      r_wr_meta      <= axi_wr_strobe_i;
      r_wr_sync      <= r_wr_meta;
      r_rd_meta      <= axi_rd_strobe_i;
      r_rd_sync      <= r_rd_meta;
      r_vs_d         <= vs_i;
      r_commit_pulse <= 1'b0;

      // Copy uses the shadow as it stood before any write landing this same cycle.
      if (w_vs_rise && r_pending) begin
        for (int i = 0; i < NUM_COEFF; i++)
          r_coeff[i*16 +: 16] <= r_shadow[i];
        r_pending      <= 1'b0;
        r_commit_pulse <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_wr_sync) begin
            r_addr  <= fir_addr_from_axi;
            r_data  <= fir_coeff_from_axi;
            r_is_wr <= 1'b1;
            r_state <= S_WR;
          end else if (r_rd_sync) begin
            r_addr      <= fir_addr_from_axi;
            r_data      <= fir_coeff_from_axi;
            r_is_wr     <= 1'b0;
            r_hist_addr <= fir_addr_from_axi[7:0];
            r_state     <= S_RD_REQ;
          end
        end
        S_WR: begin
          // A commit request set here overrides a clear from a coinciding vs edge.
          if (w_in_bank)
            r_shadow[w_idx] <= r_data;
          else if (r_addr == 16'h0200 && r_data[0])
            r_pending <= 1'b1;
          r_wr_ack <= 1'b1;
          r_state  <= S_ACK;
        end
        S_RD_REQ: begin
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_rd_data <= w_rd_mux;
          r_rd_ack  <= 1'b1;
          r_state   <= S_ACK;
        end
        S_ACK: begin
          if (!w_ack_strobe) begin
            r_wr_ack <= 1'b0;
            r_rd_ack <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign axi_wr_ack_o    = r_wr_ack;
  assign axi_rd_ack_o    = r_rd_ack;
  assign hist_bin_to_axi = r_rd_data;
  assign hist_rd_addr_o  = r_hist_addr;
  assign coeff_o         = r_coeff;
  assign commit_pulse_o  = r_commit_pulse;

endmodule

// File: tb/tb_coeff_frame_ctrl.sv
// tb/tb_coeff_frame_ctrl.sv - directed self-checking bench for coeff_frame_ctrl
`timescale 1ns/1ps

module tb_coeff_frame_ctrl;

  localparam int NC = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              axi_wr_strobe_i = 1'b0;
  logic              axi_rd_strobe_i = 1'b0;
  logic              axi_wr_ack_o, axi_rd_ack_o;
  logic [15:0]       fir_addr_from_axi = 16'h0;
  logic [15:0]       fir_coeff_from_axi = 16'h0;
  logic [15:0]       hist_bin_to_axi;
  logic              vs_i = 1'b0;
  logic [7:0]        hist_rd_addr_o;
  logic [15:0]       hist_rd_data_i = 16'h0;
  logic [16*NC-1:0]  coeff_o;
  logic              commit_pulse_o;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;
  int last_fall = 0;
  logic [7:0] ram_addr_seen;

  coeff_frame_ctrl #(.NUM_COEFF(NC), .CENTER_RST(16'h0100)) dut (
    .clk                (clk),
    .rst                (rst),
    .axi_wr_strobe_i    (axi_wr_strobe_i),
    .axi_rd_strobe_i    (axi_rd_strobe_i),
    .axi_wr_ack_o       (axi_wr_ack_o),
    .axi_rd_ack_o       (axi_rd_ack_o),
    .fir_addr_from_axi  (fir_addr_from_axi),
    .fir_coeff_from_axi (fir_coeff_from_axi),
    .hist_bin_to_axi    (hist_bin_to_axi),
    .vs_i               (vs_i),
    .hist_rd_addr_o     (hist_rd_addr_o),
    .hist_rd_data_i     (hist_rd_data_i),
    .coeff_o            (coeff_o),
    .commit_pulse_o     (commit_pulse_o)
  );

  always #5 clk = ~clk;

  // Histogram RAM model: bin 7 holds A5A5, every other bin returns {5A, bin}.
  always @(posedge clk)
    hist_rd_data_i <= (hist_rd_addr_o == 8'h07) ? 16'hA5A5 : {8'h5A, hist_rd_addr_o};

  always @(negedge clk)
    if (commit_pulse_o === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] slice(input int i);
    return coeff_o[i*16 +: 16];
  endfunction

  task automatic wait_ack(input bit rd, input bit level, output int cnt);
    cnt = 0;
    while (((rd ? axi_rd_ack_o : axi_wr_ack_o) !== level) && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if ((rd ? axi_rd_ack_o : axi_wr_ack_o) !== level) check("ack_wait_timeout", 32'(cnt), 32'(0));
  endtask

  task automatic do_access(input bit is_wr, input logic [15:0] addr, input logic [15:0] data,
                           input int vs_at, output logic [15:0] rdata, output int lat);
    bit acked;
    int fall;
    fir_addr_from_axi  = addr;
    fir_coeff_from_axi = data;
    if (is_wr) axi_wr_strobe_i = 1'b1; else axi_rd_strobe_i = 1'b1;
    lat = 0;
    acked = 1'b0;
    while (!acked && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == vs_at) vs_i = 1'b1;
      if (lat == 3) ram_addr_seen = hist_rd_addr_o;
      acked = is_wr ? (axi_wr_ack_o === 1'b1) : (axi_rd_ack_o === 1'b1);
    end
    if (!acked) check("ack_rise_timeout", 32'(lat), 32'(0));
    rdata = hist_bin_to_axi;
    axi_wr_strobe_i = 1'b0;
    axi_rd_strobe_i = 1'b0;
    wait_ack(!is_wr, 1'b0, fall);
    last_fall = fall;
    vs_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    vs_i = 1'b1;
    @(negedge clk);
    vs_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    int lat, cnt, p0;

    repeat (3) @(negedge clk);
    check("rst_wr_ack", axi_wr_ack_o, 1'b0);
    check("rst_rd_ack", axi_rd_ack_o, 1'b0);
    check("rst_pulse", commit_pulse_o, 1'b0);
    check("rst_hist_bin", hist_bin_to_axi, 16'h0);
    check("rst_hist_addr", hist_rd_addr_o, 8'h0);
    for (int i = 0; i < NC; i++)
      check($sformatf("rst_coeff%0d", i), slice(i), (i == 4) ? 16'h0100 : 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_access(1'b0, 16'h0000, 16'h0, 0, rd, lat);
    check("rd0_data", rd, 16'h0000);
    check("rd_latency", lat, 5);
    do_access(1'b0, 16'h0004, 16'h0, 0, rd, lat);
    check("rd4_center", rd, 16'h0100);

    do_access(1'b1, 16'h0003, 16'h1234, 0, rd, lat);
    check("wr_latency", lat, 4);
    check("wr_ack_fall", last_fall, 3);
    do_access(1'b0, 16'h0003, 16'h0, 0, rd, lat);
    check("rd3_shadow", rd, 16'h1234);
    check("coeff3_before_commit", slice(3), 16'h0000);

    do_access(1'b0, 16'h0107, 16'h0, 0, rd, lat);
    check("hist_rd_addr", ram_addr_seen, 8'h07);
    check("hist_bin7", rd, 16'hA5A5);
    check("hist_lat", lat, 5);
    do_access(1'b0, 16'h01FF, 16'h0, 0, rd, lat);
    check("hist_binFF", rd, 16'h5AFF);

    do_access(1'b1, 16'h0200, 16'h0001, 0, rd, lat);
    do_access(1'b0, 16'h0201, 16'h0, 0, rd, lat);
    check("pending_set", rd, 16'h0001);
    check("coeff3_pending", slice(3), 16'h0000);
    p0 = pulse_cnt;
    @(negedge clk);
    vs_i = 1'b1;
    @(negedge clk);
    check("commit_pulse_hi", commit_pulse_o, 1'b1);
    check("coeff3_commit", slice(3), 16'h1234);
    @(negedge clk);
    check("commit_pulse_lo", commit_pulse_o, 1'b0);
    vs_i = 1'b0;
    repeat (2) @(negedge clk);
    check("one_pulse", pulse_cnt - p0, 1);
    do_access(1'b0, 16'h0201, 16'h0, 0, rd, lat);
    check("pending_clear", rd, 16'h0000);

    do_access(1'b1, 16'h0200, 16'h0000, 0, rd, lat);
    do_access(1'b0, 16'h0201, 16'h0, 0, rd, lat);
    check("commit_data0_ignored", rd, 16'h0000);

    // Simultaneous strobes: write must be serviced and closed before the read.
    fir_addr_from_axi  = 16'h0005;
    fir_coeff_from_axi = 16'hBEEF;
    axi_wr_strobe_i = 1'b1;
    axi_rd_strobe_i = 1'b1;
    wait_ack(1'b0, 1'b1, cnt);
    check("both_wr_first_lat", cnt, 4);
    check("both_rd_ack_low", axi_rd_ack_o, 1'b0);
    axi_wr_strobe_i = 1'b0;
    wait_ack(1'b0, 1'b0, cnt);
    check("both_rd_ack_during_wr", axi_rd_ack_o, 1'b0);
    wait_ack(1'b1, 1'b1, cnt);
    check("both_rd_data", hist_bin_to_axi, 16'hBEEF);
    axi_rd_strobe_i = 1'b0;
    wait_ack(1'b1, 1'b0, cnt);
    @(negedge clk);

    do_access(1'b1, 16'h0003, 16'h4321, 0, rd, lat);
    p0 = pulse_cnt;
    do_access(1'b1, 16'h0200, 16'h0001, 3, rd, lat);
    check("coincide_no_pulse", pulse_cnt - p0, 0);
    check("coincide_coeff3", slice(3), 16'h1234);
    do_access(1'b0, 16'h0201, 16'h0, 0, rd, lat);
    check("coincide_pending", rd, 16'h0001);
    vs_pulse();
    check("next_frame_pulse", pulse_cnt - p0, 1);
    check("next_frame_coeff3", slice(3), 16'h4321);

    do_access(1'b1, 16'h0200, 16'h0001, 0, rd, lat);
    p0 = pulse_cnt;
    do_access(1'b1, 16'h0002, 16'h7777, 3, rd, lat);
    check("wr_copy_pulse", pulse_cnt - p0, 1);
    check("wr_copy_coeff2_old", slice(2), 16'h0000);
    check("wr_copy_coeff5", slice(5), 16'hBEEF);
    do_access(1'b0, 16'h0002, 16'h0, 0, rd, lat);
    check("wr_copy_shadow2_new", rd, 16'h7777);

    do_access(1'b1, 16'h0200, 16'h0001, 0, rd, lat);
    fir_addr_from_axi  = 16'h0001;
    fir_coeff_from_axi = 16'hAAAA;
    axi_wr_strobe_i = 1'b1;
    wait_ack(1'b0, 1'b1, cnt);
    rst = 1'b1;
    #1;
    check("rst_ack_wr", axi_wr_ack_o, 1'b0);
    check("rst_ack_rd", axi_rd_ack_o, 1'b0);
    check("rst_coeff3", slice(3), 16'h0000);
    check("rst_coeff4", slice(4), 16'h0100);
    check("rst_coeff5", slice(5), 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ack(1'b0, 1'b1, cnt);
    check("rst_fresh_wr_lat", cnt, 4);
    axi_wr_strobe_i = 1'b0;
    wait_ack(1'b0, 1'b0, cnt);
    @(negedge clk);
    do_access(1'b0, 16'h0201, 16'h0, 0, rd, lat);
    check("rst_pending_clear", rd, 16'h0000);
    do_access(1'b0, 16'h0300, 16'h0, 0, rd, lat);
    check("rd_unmapped", rd, 16'h0000);
    do_access(1'b0, 16'h0001, 16'h0, 0, rd, lat);
    check("rst_fresh_wr_data", rd, 16'hAAAA);
    do_access(1'b0, 16'h0003, 16'h0, 0, rd, lat);
    check("rst_shadow3", rd, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
